// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to MSB-first serial feeder with one-word hold register
// Define PARITY_EN to append an even-parity bit to every frame.
module serial_word_feeder #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int          CW       = $clog2(FRAME_LEN + 1);
    localparam logic [3:0]  GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] sreg;
    logic [CW-1:0]        bit_cnt;
    logic [WIDTH-1:0]     hold_data;
    logic                 hold_full;
    logic                 ready_en;
    logic [3:0]           gap_cnt;

    logic                 transfer;
    logic                 shift_last;
    logic                 gap_last;
    logic                 load_from_hold;
    logic                 load_direct;
    logic [WIDTH-1:0]     load_word;
    logic [FRAME_LEN-1:0] load_frame;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] d);
`ifdef PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    assign in_ready = ready_en && !hold_full;
    assign busy     = (state != IDLE) || hold_full;
    assign transfer = in_valid && in_ready;

    // A pending hold word always wins over a bypass; bypass only happens with hold empty.
    always_comb begin
        shift_last     = (state == SHIFT) && (bit_cnt == CW'(FRAME_LEN));
        gap_last       = (state == GAP) && (gap_cnt == GAP_LAST);
        load_from_hold = hold_full && ((state == IDLE) || gap_last ||
                                       (shift_last && (GAP_CYCLES == 0)));
        load_direct    = transfer && (state == IDLE) && !hold_full;
        load_word      = load_from_hold ? hold_data : in_data;
        load_frame     = build_frame(load_word);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            ready_en  <= 1'b0;
            gap_cnt   <= '0;
            w         <= IDLE_LEVEL;
            w_valid   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            word_done <= 1'b0;

            // Draining and refilling the hold register in the same cycle keeps it full.
            if (transfer && !load_direct) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end else if (load_from_hold) begin
                hold_full <= 1'b0;
            end

            if (load_from_hold || load_direct) begin
                state   <= SHIFT;
                w       <= load_frame[FRAME_LEN-1];
                sreg    <= load_frame << 1;
                bit_cnt <= CW'(1);
                w_valid <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        if (!shift_last) begin
                            w         <= sreg[FRAME_LEN-1];
                            sreg      <= sreg << 1;
                            bit_cnt   <= bit_cnt + CW'(1);
                            word_done <= (bit_cnt == CW'(FRAME_LEN - 1));
                        end else begin
                            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_cnt <= '0;
                            bit_cnt <= '0;
                            w       <= IDLE_LEVEL;
                            w_valid <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_last) state <= IDLE;
                        else          gap_cnt <= gap_cnt + 4'd1;
                    end
                    default: begin
                        w       <= IDLE_LEVEL;
                        w_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - scoreboard bench for serial_word_feeder (GAP_CYCLES 0 and 2)
module tb_serial_word_feeder;

`ifdef PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam logic IDLE_LVL = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data_a = '0, in_data_b = '0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic       in_ready_a, w_a, w_valid_a, busy_a, word_done_a;
    logic       in_ready_b, w_b, w_valid_b, busy_b, word_done_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] qa[$];
    logic [1:0] qb[$];
    int         ta[$];
    int         tb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_feeder #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(IDLE_LVL)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .w(w_a), .w_valid(w_valid_a), .busy(busy_a),
        .word_done(word_done_a));

    serial_word_feeder #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(IDLE_LVL)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .w(w_b), .w_valid(w_valid_b), .busy(busy_b),
        .word_done(word_done_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] mkf(input logic [7:0] d, input logic p);
`ifdef PARITY_EN
        return {d, p};
`else
        return {1'b0, d};
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (w_valid_a) begin
                if (qa.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL a_extra_bit: got w=%0b with no frame bit expected", w_a);
                end else begin
                    logic [1:0] e;
                    e = qa.pop_front();
                    chk("a_w", w_a, e[1]);
                    chk("a_word_done", word_done_a, e[0]);
                end
                if (word_done_a) ta.push_back(cyc);
            end else begin
                chk("a_idle_w", w_a, IDLE_LVL);
                chk("a_idle_done", word_done_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (w_valid_b) begin
                if (qb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b_extra_bit: got w=%0b with no frame bit expected", w_b);
                end else begin
                    logic [1:0] e;
                    e = qb.pop_front();
                    chk("b_w", w_b, e[1]);
                    chk("b_word_done", word_done_b, e[0]);
                end
                if (word_done_b) tb.push_back(cyc);
            end else begin
                chk("b_idle_w", w_b, IDLE_LVL);
                chk("b_idle_done", word_done_b, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send_a(input logic [7:0] d, input logic p);
        logic [8:0] f;
        logic       r;
        bit         ok;
        f = mkf(d, p);
        ok = 0;
        in_data_a  = d;
        in_valid_a = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            r = in_ready_a;
            @(posedge clk); #1;
            if (r) begin
                for (int i = FL - 1; i >= 0; i--) qa.push_back({f[i], (i == 0) ? 1'b1 : 1'b0});
                ok = 1;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL a_accept: word %0h not accepted, in_ready=%0b, expected 1", d, in_ready_a);
        end
    endtask

    task automatic send_b(input logic [7:0] d, input logic p);
        logic [8:0] f;
        logic       r;
        bit         ok;
        f = mkf(d, p);
        ok = 0;
        in_data_b  = d;
        in_valid_b = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            r = in_ready_b;
            @(posedge clk); #1;
            if (r) begin
                for (int i = FL - 1; i >= 0; i--) qb.push_back({f[i], (i == 0) ? 1'b1 : 1'b0});
                ok = 1;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b_accept: word %0h not accepted, in_ready=%0b, expected 1", d, in_ready_b);
        end
    endtask

    task automatic drain(input bit on_b);
        bit ok;
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clk); #1;
            if (on_b) ok = (qb.size() == 0) && !busy_b;
            else      ok = (qa.size() == 0) && !busy_a;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_%s: pending bits %0d, busy %0b, expected 0/0", on_b ? "b" : "a",
                     on_b ? qb.size() : qa.size(), on_b ? busy_b : busy_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Test 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t1_in_ready", in_ready_a, 1);
            chk("t1_busy", busy_a, 0);
            chk("t1_w_valid", w_valid_a, 0);
            chk("t1_w", w_a, IDLE_LVL);
        end

        // Test 2: single word B4
        send_a(8'hB4, 1'b0);
        in_valid_a = 1'b0;
        drain(0);
        chk("t2_done_count", ta.size(), 1);

        // Test 3: back-to-back stream FF, 00, A5
        ta.delete();
        send_a(8'hFF, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'hA5, 1'b0);
        in_valid_a = 1'b0;
        drain(0);
        chk("t3_done_count", ta.size(), 3);
        if (ta.size() == 3) begin
            chk("t3_spacing1", ta[1] - ta[0], FL);
            chk("t3_spacing2", ta[2] - ta[1], FL);
        end

        // Test 4: gap of 2 cycles between frames
        send_b(8'h81, 1'b0);
        send_b(8'h81, 1'b0);
        in_valid_b = 1'b0;
        drain(1);
        chk("t4_done_count", tb.size(), 2);
        if (tb.size() == 2) chk("t4_spacing", tb[1] - tb[0], FL + 2);

        // Test 5: reset on the 4th bit of C3 with the hold register full
        n0 = ta.size();
        send_a(8'hC3, 1'b0);
        send_a(8'h5A, 1'b0);
        in_valid_a = 1'b0;
        chk("t5_hold_full", in_ready_a, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        qa.delete();
        #1;
        chk("t5_async_w_valid", w_valid_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_w_valid", w_valid_a, 0);
        chk("t5_busy", busy_a, 0);
        @(posedge clk); #1;
        chk("t5_in_ready", in_ready_a, 1);
        chk("t5_no_done", ta.size(), n0);
        send_a(8'h96, 1'b0);
        in_valid_a = 1'b0;
        drain(0);
        chk("t5_new_done", ta.size(), n0 + 1);

`ifdef PARITY_EN
        // Test 6: parity bit 1 for 07, 0 for 03
        n0 = ta.size();
        send_a(8'h07, 1'b1);
        in_valid_a = 1'b0;
        drain(0);
        send_a(8'h03, 1'b0);
        in_valid_a = 1'b0;
        drain(0);
        chk("t6_done_count", ta.size(), n0 + 2);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
